// File: rtl/digest_tx_pkg.sv
// Shared types and constants for the SHA-256 digest byte-serial transmitter.
// nib2ascii maps a nibble to its lowercase ASCII hex character.
package digest_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam int         RAW_BYTES = 32;
  localparam int         HEX_CHARS = 64;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
    else             ch = 8'h57 + {4'h0, nib};
    return ch;
  endfunction

endpackage

// File: rtl/digest_tx.sv
// Captures fin_hash on hash_done and streams it as raw bytes or lowercase hex,
// optionally followed by CR/LF, over a registered valid/ready interface.
module digest_tx
  import digest_tx_pkg::*;
#(
  parameter bit HEX_ASCII  = 1'b1,
  parameter bit APPEND_EOL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hash_done,
  input  logic [255:0] fin_hash,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         busy,
  output logic         drop_pulse,
  output tx_state_t    dbg_state
);

  // Handshake: a character moves when tx_valid && tx_ready at a rising edge;
  // tx_data is held unchanged while tx_valid is high and tx_ready is low.

  localparam logic [5:0] LAST_IDX = HEX_ASCII ? 6'(HEX_CHARS - 1) : 6'(RAW_BYTES - 1);

  tx_state_t    state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic [255:0] shadow_q, shadow_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         drop_q, drop_d;

  logic         xfer;
  logic         final_xfer;
  logic         accept;
  logic [3:0]   sel_nib;
  logic [7:0]   sel_byte;

  assign xfer       = tx_valid && tx_ready;
  // The last character of the whole stream frees the shadow for a new digest.
  assign final_xfer = xfer && ((state_q == LF) ||
                               (!APPEND_EOL && state_q == DATA && idx_q == LAST_IDX));
  assign accept     = hash_done && ((state_q == IDLE) || final_xfer);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    drop_d   = hash_done && !accept;
    case (state_q)
      DATA: if (xfer) begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 6'd0;
          state_d = APPEND_EOL ? CR : IDLE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      CR:      if (xfer) state_d = LF;
      LF:      if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shadow_d = fin_hash;
      idx_d    = 6'd0;
      state_d  = DATA;
    end
  end

  // Next character is selected from next-state values so tx_data is registered.
  always_comb begin
    sel_nib   = shadow_d[{~idx_d, 2'b00} +: 4];
    sel_byte  = shadow_d[{~idx_d[4:0], 3'b000} +: 8];
    tx_data_d = 8'h00;
    case (state_d)
      DATA:    tx_data_d = HEX_ASCII ? nib2ascii(sel_nib) : sel_byte;
      CR:      tx_data_d = ASCII_CR;
      LF:      tx_data_d = ASCII_LF;
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      shadow_q  <= '0;
      tx_data_q <= 8'h00;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
    end
  end

  assign tx_valid   = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_data    = tx_data_q;
  assign drop_pulse = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_digest_tx.sv
// Directed bench for digest_tx: hex+EOL and raw instances, backpressure,
// dropped and back-to-back hash_done, and mid-stream reset.
module tb_digest_tx;
  import digest_tx_pkg::*;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hash_done_hex = 1'b0;
  logic         hash_done_raw = 1'b0;
  logic [255:0] fin_hash = '0;
  logic         tx_ready = 1'b1;
  logic         ready_raw = 1'b1;
  logic         rand_en = 1'b0;

  logic         tx_valid, busy, drop_pulse;
  logic [7:0]   tx_data;
  tx_state_t    dbg_state;
  logic         raw_valid, raw_busy, raw_drop;
  logic [7:0]   raw_data;
  tx_state_t    raw_state;

  int checks = 0;
  int errors = 0;
  int hex_xfers = 0;
  int busy_cnt = 0;
  int drops_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] exp_raw_q[$];

  digest_tx #(.HEX_ASCII(1'b1), .APPEND_EOL(1'b1)) dut_hex (
    .clk(clk), .rst(rst), .hash_done(hash_done_hex), .fin_hash(fin_hash),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .drop_pulse(drop_pulse), .dbg_state(dbg_state)
  );

  digest_tx #(.HEX_ASCII(1'b0), .APPEND_EOL(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .hash_done(hash_done_raw), .fin_hash(fin_hash),
    .tx_valid(raw_valid), .tx_data(raw_data), .tx_ready(ready_raw),
    .busy(raw_busy), .drop_pulse(raw_drop), .dbg_state(raw_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_hex(input logic [255:0] h);
    logic [3:0] nib;
    for (int i = 0; i < 64; i++) begin
      nib = h[255 - 4*i -: 4];
      exp_q.push_back(nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h61 + {4'h0, nib} - 8'd10);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_hex(input logic [255:0] h);
    fin_hash = h;
    hash_done_hex = 1'b1;
    @(posedge clk); #1;
    hash_done_hex = 1'b0;
    fin_hash = {8{$urandom()}};
  endtask

  task automatic wait_hex_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 256'(n < budget), 256'(1));
  endtask

  // Hex monitor: scoreboard pop on transfer, stall stability, busy/drop counts.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 256'(tx_valid), 256'(1));
        check("stall_data", 256'(tx_data), 256'(prev_data));
      end
      if (busy) busy_cnt++;
      if (drop_pulse) drops_seen++;
      if (tx_valid && tx_ready) begin
        hex_xfers++;
        if (exp_q.size() == 0) check("hex_extra_char", 256'(tx_data), 256'h100);
        else check("hex_char", 256'(tx_data), 256'(exp_q.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && raw_valid && ready_raw) begin
      if (exp_raw_q.size() == 0) check("raw_extra_char", 256'(raw_data), 256'h100);
      else check("raw_char", 256'(raw_data), 256'(exp_raw_q.pop_front()));
    end
  end

  initial begin
    int n;
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 256'(tx_valid), 256'(0));
    check("rst_data", 256'(tx_data), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_drop", 256'(drop_pulse), 256'(0));
    check("rst_raw_valid", 256'(raw_valid), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Hex + EOL, ready held high
    push_hex(ABC);
    busy_cnt = 0;
    pulse_hex(ABC);
    check("lat_valid", 256'(tx_valid), 256'(1));
    check("lat_busy", 256'(busy), 256'(1));
    check("lat_first", 256'(tx_data), 256'(8'h62));
    wait_hex_drain("hex_drain", 200);
    check("busy_cycles", 256'(busy_cnt), 256'(66));
    check("hex_idle_valid", 256'(tx_valid), 256'(0));

    // Raw, no EOL
    for (int i = 0; i < 32; i++) exp_raw_q.push_back(ABC[255 - 8*i -: 8]);
    fin_hash = ABC;
    hash_done_raw = 1'b1;
    @(posedge clk); #1;
    hash_done_raw = 1'b0;
    fin_hash = '1;
    check("raw_first", 256'(raw_data), 256'(8'hBA));
    n = 0;
    while ((exp_raw_q.size() != 0 || raw_busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("raw_drain", 256'(n < 100), 256'(1));
    check("raw_idle_valid", 256'(raw_valid), 256'(0));
    check("raw_count", 256'(exp_raw_q.size()), 256'(0));

    // Random backpressure
    rand_en = 1'b1;
    push_hex(ABC);
    pulse_hex(ABC);
    wait_hex_drain("bp_drain", 2000);
    rand_en = 1'b0;
    @(posedge clk); #1;

    // Dropped hash_done mid-stream, then back-to-back capture on LF
    drops_seen = 0;
    push_hex(ABC);
    pulse_hex(ABC);
    base = hex_xfers;
    n = 0;
    while (hex_xfers - base < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drop_reach", 256'(n < 100), 256'(1));
    pulse_hex(256'h0);
    check("drop_hi", 256'(drop_pulse), 256'(1));
    check("drop_busy", 256'(busy), 256'(1));
    @(posedge clk); #1;
    check("drop_lo", 256'(drop_pulse), 256'(0));
    n = 0;
    while (!(tx_valid && tx_data == 8'h0A) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("lf_reach", 256'(n < 200), 256'(1));
    push_hex(256'h0);
    pulse_hex(256'h0);
    check("b2b_valid", 256'(tx_valid), 256'(1));
    check("b2b_busy", 256'(busy), 256'(1));
    check("b2b_first", 256'(tx_data), 256'(8'h30));
    @(posedge clk); #1;
    check("b2b_nodrop", 256'(drop_pulse), 256'(0));
    wait_hex_drain("b2b_drain", 300);
    check("drop_total", 256'(drops_seen), 256'(1));

    // Reset mid-stream
    push_hex(ABC);
    pulse_hex(ABC);
    base = hex_xfers;
    n = 0;
    while (hex_xfers - base < 20 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach", 256'(n < 100), 256'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", 256'(tx_valid), 256'(0));
    check("arst_busy", 256'(busy), 256'(0));
    check("arst_data", 256'(tx_data), 256'(0));
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 256'(tx_valid), 256'(0));
    end
    push_hex(ABC);
    pulse_hex(ABC);
    check("restart_first", 256'(tx_data), 256'(8'h62));
    wait_hex_drain("restart_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digest_tx.md
# digest_tx

Byte-serial transmitter for the 256-bit SHA-256 digest. It sits downstream of the hash top-level, which accepts message bytes over the UART-like receive side. On `hash_done` it captures `fin_hash` and emits the digest as a byte stream on a valid/ready transmit interface that feeds a UART TX or host FIFO. The stream is either 32 raw bytes or 64 lowercase ASCII hex characters, with an optional CR/LF terminator.

## Interface
- `HEX_ASCII`, default 1: 1 = send 64 ASCII hex characters; 0 = send 32 raw bytes.
- `APPEND_EOL`, default 1: 1 = append 8'h0D then 8'h0A after the digest characters; 0 = no terminator.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `hash_done` in 1: single-cycle pulse meaning `fin_hash` is valid in this cycle.
- `fin_hash` in 256: digest, H0 in [255:224].
- `tx_valid` out 1: `tx_data` holds a character.
- `tx_data` out 8: current character.
- `tx_ready` in 1: sink accepts the character; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `busy` out 1: a digest is captured and not fully sent.
- `drop_pulse` out 1: one-cycle pulse when a `hash_done` is ignored.

## Operation
- States: IDLE, DATA, CR, LF.
- Total characters N = (HEX_ASCII ? 64 : 32) + (APPEND_EOL ? 2 : 0).
- IDLE:
  - On `hash_done`, register `fin_hash` into a 256-bit shadow, clear the character index, and go to DATA.
- DATA:
  - Character index i counts 0 to 63 (hex) or 0 to 31 (raw).
  - Raw mode: byte i = shadow[255-8i -: 8], MSB byte first.
  - Hex mode: nibble i = shadow[255-4i -: 4], high nibble first. Values 0–9 map to 8'h30–8'h39; 10–15 map to 8'h61–8'h66.
  - Each transfer increments i. The transfer of the last data character goes to CR if APPEND_EOL is 1, otherwise to IDLE.
- CR: sends 8'h0D, then goes to LF on transfer.
- LF: sends 8'h0A, then goes to IDLE on transfer.
- `tx_valid` = 1 in DATA, CR and LF; 0 in IDLE.
- `tx_data` and `tx_valid` are registered outputs. `tx_data` stays stable while `tx_valid && !tx_ready`.
- `busy` = 1 in any state other than IDLE.
- `hash_done` while busy and not on the final transfer cycle: ignored, shadow unchanged, `drop_pulse` asserted the next cycle.
- `hash_done` in the same cycle as the final transfer (last data character, or LF): accepted.
  - New digest captured, index reset, state goes to DATA.
  - No drop, no idle gap.
- `tx_ready` high while `tx_valid` is low: no effect.
- Shadow register is loaded only on an accepted `hash_done`. `fin_hash` may change freely after capture.

## Timing
- Reset values:
  - `tx_valid` = 0, `tx_data` = 8'h00, `busy` = 0, `drop_pulse` = 0.
  - State = IDLE, index = 0, shadow = 0.
- Reset asserted mid-stream: outputs drop to their reset values immediately (asynchronously). The partial digest is discarded and not resumed.
- Latency: with `hash_done` sampled at edge k, `tx_valid` = 1 with the first character after edge k; `busy` = 1 from the same edge.
- Throughput: one character per cycle while `tx_ready` is held high. A full hex+EOL digest takes 66 cycles.
- `busy` falls on the edge of the final transfer, unless a back-to-back capture occurs on that edge.
- `drop_pulse` is exactly one cycle wide per dropped `hash_done`.

## Structure
- Package `digest_tx_pkg`:
  - State enum `tx_state_t` (IDLE, DATA, CR, LF).
  - Constants `ASCII_CR` = 8'h0D, `ASCII_LF` = 8'h0A, `RAW_BYTES` = 32, `HEX_CHARS` = 64.
  - Function `nib2ascii(logic [3:0]) -> logic [7:0]`.
- No sub-module. Single module with the FSM, a 6-bit index counter and the shadow register.
- Character selection is a combinational mux from shadow and index, registered into `tx_data` on state and handshake updates.

## Test plan
- Hex+EOL, SHA-256("abc") = ba7816bf…f20015ad, `tx_ready` tied high -> 66 consecutive transfers: 8'h62, 8'h61, 8'h37, 8'h38 … 8'h61, 8'h64, 8'h0D, 8'h0A. `busy` is high for exactly 66 cycles.
- Raw, no EOL, same digest -> 32 transfers 8'hBA, 8'h78, 8'h16 … 8'h15, 8'hAD; then `tx_valid` = 0.
- Random `tx_ready` backpressure (about 50%) on the hex+EOL digest -> sequence identical to the first scenario, `tx_data` stable during every stall, no duplicated or skipped characters.
- Second `hash_done` with digest 256'h0 at character 10 -> `drop_pulse` one cycle, first stream completes unchanged. Third `hash_done` with digest 256'h0 on the LF transfer cycle -> accepted, 64 × 8'h30 then CR, LF follow with no gap.
- `rst` asserted at character 20 for 2 cycles -> `tx_valid`, `busy` and `tx_data` go to 0 immediately. After release the block stays IDLE until the next `hash_done`, then restarts from character 0.
